// File: rtl/switch_endpoint.sv
// ==========================================================================
// switch_endpoint : TX/RX FIFO endpoint for one switch port (valid/ack)
// rev 1.0
// ==========================================================================
`default_nettype none

module switch_endpoint #(
   parameter int DW    = 4,
   parameter int AW    = 2,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   // local TX side
   input  logic          tx_wr,
   input  logic [AW-1:0] tx_adr,
   input  logic [DW-1:0] tx_dat,
   output logic          tx_full,
   // switch TX side
   output logic [AW-1:0] adr_i,
   output logic [DW-1:0] dat_i,
   output logic          validtx,
   input  logic          acktx,
   // switch RX side
   input  logic          validrx,
   input  logic [AW-1:0] rx_adr_i,
   input  logic [DW-1:0] rx_dat_i,
   output logic          ackrx,
   // local RX side
   input  logic          rx_rd,
   output logic [AW-1:0] rx_adr,
   output logic [DW-1:0] rx_dat,
   output logic          rx_empty,
   // status
   output logic          err_ovf,
   output logic          err_udf,
   output logic          tx_stall,
   output logic [CW-1:0] tx_cnt,
   output logic [CW-1:0] rx_cnt
);

   localparam int            PW        = $clog2(DEPTH);
   localparam int            WW        = AW + DW;
   localparam logic [PW:0]   FULL_CNT  = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] CW_ONE    = CW'(1);
   localparam logic [CW-1:0] STALL_MAX = '1;

   // ---------------------------------------------------------------- TX FIFO
   logic [WW-1:0] tx_mem [DEPTH];
   logic [PW-1:0] tx_wp;
   logic [PW-1:0] tx_rp;
   logic [PW:0]   tx_count;
   logic [PW:0]   tx_count_nxt;
   logic          tx_push;
   logic          tx_pop;
   logic          tx_drop;
   logic [CW-1:0] stall_tmr;

   assign tx_full = (tx_count == FULL_CNT);
   assign tx_pop  = validtx & acktx;
   // A pop in the same cycle frees the head slot, so a push at full still fits.
   assign tx_push = tx_wr & (~tx_full | tx_pop);
   assign tx_drop = tx_wr & ~tx_push;

   assign {adr_i, dat_i} = tx_mem[tx_rp];

   always_comb begin
      tx_count_nxt = tx_count;
      if (tx_push && !tx_pop)
         tx_count_nxt = tx_count + CNT_ONE;
      else if (tx_pop && !tx_push)
         tx_count_nxt = tx_count - CNT_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (tx_push)
         tx_mem[tx_wp] <= {tx_adr, tx_dat};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_wp     <= '0;
         tx_rp     <= '0;
         tx_count  <= '0;
         validtx   <= 1'b0;
         tx_cnt    <= '0;
         err_ovf   <= 1'b0;
         stall_tmr <= '0;
         tx_stall  <= 1'b0;
      end else begin
         if (tx_push)
            tx_wp <= tx_wp + PTR_ONE;
         if (tx_pop) begin
            tx_rp  <= tx_rp + PTR_ONE;
            tx_cnt <= tx_cnt + CW_ONE;
         end
         tx_count <= tx_count_nxt;
         validtx  <= (tx_count_nxt != '0);
         if (tx_drop)
            err_ovf <= 1'b1;
         // Timer saturates at its maximum; the flag is sticky until reset.
         if (validtx && !acktx) begin
            if (stall_tmr != STALL_MAX)
               stall_tmr <= stall_tmr + CW_ONE;
            if (stall_tmr == STALL_MAX - CW_ONE)
               tx_stall <= 1'b1;
         end else begin
            stall_tmr <= '0;
         end
      end
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [WW-1:0] rx_mem [DEPTH];
   logic [PW-1:0] rx_wp;
   logic [PW-1:0] rx_rp;
   logic [PW:0]   rx_count;
   logic [PW:0]   rx_count_nxt;
   logic          rx_push;
   logic          rx_pop;

   assign rx_empty = (rx_count == '0);
   assign rx_push  = validrx & ackrx;
   assign rx_pop   = rx_rd & ~rx_empty;

   assign {rx_adr, rx_dat} = rx_mem[rx_rp];

   always_comb begin
      rx_count_nxt = rx_count;
      if (rx_push && !rx_pop)
         rx_count_nxt = rx_count + CNT_ONE;
      else if (rx_pop && !rx_push)
         rx_count_nxt = rx_count - CNT_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (rx_push)
         rx_mem[rx_wp] <= {rx_adr_i, rx_dat_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_count <= '0;
         ackrx    <= 1'b0;
         rx_cnt   <= '0;
         err_udf  <= 1'b0;
      end else begin
         if (rx_push) begin
            rx_wp  <= rx_wp + PTR_ONE;
            rx_cnt <= rx_cnt + CW_ONE;
         end
         if (rx_pop)
            rx_rp <= rx_rp + PTR_ONE;
         rx_count <= rx_count_nxt;
         // Ack looks at the post-edge occupancy, so an accepted word always fits.
         ackrx <= validrx & (rx_count_nxt < FULL_CNT);
         if (rx_rd && rx_empty)
            err_udf <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_switch_endpoint.sv
// ==========================================================================
// tb_switch_endpoint : directed self-checking bench for switch_endpoint
// rev 1.0
// ==========================================================================
`default_nettype none

module tb_switch_endpoint;

   localparam int DW    = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int CW    = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          tx_wr;
   logic [AW-1:0] tx_adr;
   logic [DW-1:0] tx_dat;
   logic          tx_full;
   logic [AW-1:0] adr_i;
   logic [DW-1:0] dat_i;
   logic          validtx;
   logic          acktx;
   logic          validrx;
   logic [AW-1:0] rx_adr_i;
   logic [DW-1:0] rx_dat_i;
   logic          ackrx;
   logic          rx_rd;
   logic [AW-1:0] rx_adr;
   logic [DW-1:0] rx_dat;
   logic          rx_empty;
   logic          err_ovf;
   logic          err_udf;
   logic          tx_stall;
   logic [CW-1:0] tx_cnt;
   logic [CW-1:0] rx_cnt;

   int passed = 0;
   int total  = 0;

   switch_endpoint #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tx_wr    (tx_wr),
      .tx_adr   (tx_adr),
      .tx_dat   (tx_dat),
      .tx_full  (tx_full),
      .adr_i    (adr_i),
      .dat_i    (dat_i),
      .validtx  (validtx),
      .acktx    (acktx),
      .validrx  (validrx),
      .rx_adr_i (rx_adr_i),
      .rx_dat_i (rx_dat_i),
      .ackrx    (ackrx),
      .rx_rd    (rx_rd),
      .rx_adr   (rx_adr),
      .rx_dat   (rx_dat),
      .rx_empty (rx_empty),
      .err_ovf  (err_ovf),
      .err_udf  (err_udf),
      .tx_stall (tx_stall),
      .tx_cnt   (tx_cnt),
      .rx_cnt   (rx_cnt)
   );

   always #5 clk_i = ~clk_i;

   // Step one cycle; everything is then observed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tx_word(input int a, input int d);
      tx_wr  = 1'b1;
      tx_adr = AW'(a);
      tx_dat = DW'(d);
   endtask

   task automatic rx_word(input int k);
      rx_dat_i = DW'(k);
      rx_adr_i = AW'(k);
   endtask

   initial begin
      rst_i = 1'b1; tx_wr = 1'b0; tx_adr = '0; tx_dat = '0; acktx = 1'b0;
      validrx = 1'b0; rx_adr_i = '0; rx_dat_i = '0; rx_rd = 1'b0;
      tick(); tick();
      rst_i = 1'b0;

      // reset state
      check("rst_validtx",  32'(validtx),  0);
      check("rst_tx_full",  32'(tx_full),  0);
      check("rst_rx_empty", 32'(rx_empty), 1);
      check("rst_ackrx",    32'(ackrx),    0);
      check("rst_flags",    32'({err_ovf, err_udf, tx_stall}), 0);
      check("rst_counts",   32'({tx_cnt, rx_cnt}), 0);

      // three words, acktx held high: back-to-back transfers
      acktx = 1'b1;
      tx_word(1, 5); tick();
      check("t1_validtx_rise", 32'(validtx), 1);
      check("t1_head1", 32'({adr_i, dat_i}), 32'h15);
      check("t1_cnt0",  32'(tx_cnt), 0);
      tx_word(2, 6); tick();
      check("t1_head2", 32'({adr_i, dat_i}), 32'h26);
      check("t1_cnt1",  32'(tx_cnt), 1);
      tx_word(3, 7); tick();
      check("t1_head3", 32'({adr_i, dat_i}), 32'h37);
      check("t1_valid3", 32'(validtx), 1);
      tx_wr = 1'b0; tick();
      check("t1_validtx_low", 32'(validtx), 0);
      check("t1_cnt3", 32'(tx_cnt), 3);
      acktx = 1'b0;

      // five pushes into a depth-4 FIFO with no ack
      tx_word(0, 1); tick();
      tx_word(1, 2); tick();
      tx_word(2, 3); tick();
      check("t2_not_full3", 32'(tx_full), 0);
      tx_word(3, 4); tick();
      check("t2_full4", 32'(tx_full), 1);
      check("t2_no_ovf4", 32'(err_ovf), 0);
      tx_word(0, 8); tick();
      check("t2_ovf5", 32'(err_ovf), 1);
      check("t2_head_stable", 32'({adr_i, dat_i}), 32'h01);
      tx_wr = 1'b0; tick();
      check("t2_head_hold", 32'({adr_i, dat_i}), 32'h01);
      check("t2_valid_hold", 32'(validtx), 1);
      acktx = 1'b1;
      tick();
      check("t2_drain1", 32'({adr_i, dat_i}), 32'h12);
      check("t2_full_clr", 32'(tx_full), 0);
      tick();
      check("t2_drain2", 32'({adr_i, dat_i}), 32'h23);
      tick();
      check("t2_drain3", 32'({adr_i, dat_i}), 32'h34);
      tick();
      check("t2_empty", 32'(validtx), 0);
      check("t2_cnt7", 32'(tx_cnt), 7);
      tick();
      check("t2_ack_ignored", 32'(tx_cnt), 7);
      acktx = 1'b0;

      // RX fills to depth, then ack drops
      validrx = 1'b1; rx_word(0); tick();
      check("t3_ack_rise", 32'(ackrx), 1);
      check("t3_empty0", 32'(rx_empty), 1);
      tick();
      check("t3_nonempty", 32'(rx_empty), 0);
      rx_word(1); tick();
      rx_word(2); tick();
      rx_word(3); tick();
      check("t3_ack_drop", 32'(ackrx), 0);
      check("t3_rxcnt4", 32'(rx_cnt), 4);
      rx_word(4); tick();
      check("t3_ack_low", 32'(ackrx), 0);
      check("t3_rxcnt_hold", 32'(rx_cnt), 4);
      check("t3_head0", 32'({rx_adr, rx_dat}), 32'h00);

      // one pop frees a slot: ack reasserts and word 4 is taken
      rx_rd = 1'b1; tick();
      rx_rd = 1'b0;
      check("t4_ack_re", 32'(ackrx), 1);
      check("t4_head1", 32'({rx_adr, rx_dat}), 32'h11);
      tick();
      check("t4_rxcnt5", 32'(rx_cnt), 5);
      check("t4_ack_drop", 32'(ackrx), 0);
      check("t4_head_hold", 32'({rx_adr, rx_dat}), 32'h11);
      validrx = 1'b0;

      // drain RX, then underflow
      rx_rd = 1'b1; tick();
      check("t4_head2", 32'({rx_adr, rx_dat}), 32'h22);
      tick();
      check("t4_head3", 32'({rx_adr, rx_dat}), 32'h33);
      tick();
      check("t4_head4", 32'({rx_adr, rx_dat}), 32'h04);
      check("t4_no_udf", 32'(err_udf), 0);
      tick();
      check("t4_rx_empty", 32'(rx_empty), 1);
      check("t4_no_udf2", 32'(err_udf), 0);
      tick();
      rx_rd = 1'b0;
      check("t5_udf", 32'(err_udf), 1);
      check("t5_rxcnt_keep", 32'(rx_cnt), 5);

      // stall: 15 cycles of validtx without ack with CW=4
      tx_word(2, 9); tick();
      tx_wr = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      check("t5_no_stall14", 32'(tx_stall), 0);
      tick();
      check("t5_stall15", 32'(tx_stall), 1);
      tick(); tick();
      check("t5_stall_sticky", 32'(tx_stall), 1);
      check("t5_head_stall", 32'({adr_i, dat_i}), 32'h29);
      acktx = 1'b1; tick();
      acktx = 1'b0;
      check("t5_xfer_done", 32'(validtx), 0);
      check("t5_cnt8", 32'(tx_cnt), 8);
      check("t5_stall_keep", 32'(tx_stall), 1);

      // reset mid-stream with two words queued on each side
      validrx = 1'b1; rx_word(6);
      tx_word(1, 10); tick();
      tx_word(2, 11); tick();
      tx_wr = 1'b0; rx_word(7); tick();
      check("t6_validtx_pre", 32'(validtx), 1);
      check("t6_rx_pre", 32'(rx_empty), 0);
      check("t6_rxcnt_pre", 32'(rx_cnt), 7);
      rst_i = 1'b1; tick();
      check("t6_validtx", 32'(validtx), 0);
      check("t6_ackrx", 32'(ackrx), 0);
      check("t6_rx_empty", 32'(rx_empty), 1);
      check("t6_tx_full", 32'(tx_full), 0);
      check("t6_counts", 32'({tx_cnt, rx_cnt}), 0);
      check("t6_flags", 32'({err_ovf, err_udf, tx_stall}), 0);
      rst_i = 1'b0; validrx = 1'b0; tick();
      check("t6_validtx_after", 32'(validtx), 0);
      check("t6_rx_empty_after", 32'(rx_empty), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
